l1_miss_tracker: RTL and testbench

- Parametrised successor to the L1 load miss queue; sits between the L1 data cache tag stage and the L2 request arbiter.
- Tracks outstanding L1 misses in NUM_ENTRIES slots and combines unsynchronized misses to the same line.
- Issues requests to L2 oldest-first, where the previous queue used arbitrary order.
- Wakes all waiting threads on each L2 response; supports NUM_ENTRIES < NUM_THREADS with back-pressure on the miss port.

---
 rtl/l1_miss_tracker.sv | 182 ++++++++++++++++++
 tb/tb_l1_miss_tracker.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_miss_tracker.sv
// l1_miss_tracker: tracks outstanding L1 load misses between the tag stage
// and the L2 request arbiter. Non-sync misses to a line that is already
// outstanding are merged into the existing entry. Requests go to L2 oldest
// first, and every L2 response wakes all threads waiting on that entry.
// Optional feature macro: L1_MISS_TRACKER_PERF_EN adds the performance
// outputs perf_miss_combined, perf_miss_stall and perf_peak_occupancy.
module l1_miss_tracker #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_ENTRIES = 4,
  parameter int ADDR_WIDTH  = 26,
  parameter int IDX_WIDTH   = $clog2(NUM_ENTRIES),
  localparam int TIDX_WIDTH = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cache_miss,
  input  logic [ADDR_WIDTH-1:0]  cache_miss_adr,
  input  logic [TIDX_WIDTH-1:0]  cache_miss_thread_idx,
  input  logic                   cache_miss_sync,
  output logic                   cache_miss_accept,
  output logic                   dequeue_ready,
  input  logic                   dequeue_ack,
  output logic [ADDR_WIDTH-1:0]  dequeue_adr,
  output logic [IDX_WIDTH-1:0]   dequeue_idx,
  output logic                   dequeue_sync,
  input  logic                   l2_response_valid,
  input  logic [IDX_WIDTH-1:0]   l2_response_idx,
  output logic [NUM_THREADS-1:0] wake_bitmap,
  output logic [IDX_WIDTH:0]     occupancy
`ifdef L1_MISS_TRACKER_PERF_EN
  ,
  output logic                   perf_miss_combined,
  output logic                   perf_miss_stall,
  output logic [IDX_WIDTH:0]     perf_peak_occupancy
`endif
);

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_ISSUED  = 2'd2
  } entry_state_t;

  entry_state_t           state      [NUM_ENTRIES];
  logic [ADDR_WIDTH-1:0]  line_adr   [NUM_ENTRIES];
  logic                   entry_sync [NUM_ENTRIES];
  logic [NUM_THREADS-1:0] waiters    [NUM_ENTRIES];
  // elder[i][j] = 1 when entry j was allocated before entry i. Clearing a
  // column on reallocation keeps the ordering exact with no counter wrap.
  logic [NUM_ENTRIES-1:0] elder      [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] is_free, is_pending, is_match, is_oldest;
  logic [NUM_ENTRIES-1:0] thread_busy, alloc_mask;
  logic [NUM_THREADS-1:0] thread_bit;
  logic                   resp_hit, free_any, combine_hit;
  logic                   do_combine, do_alloc, deq_fire;
  logic [IDX_WIDTH-1:0]   alloc_idx, combine_idx, deq_idx;
  logic [IDX_WIDTH:0]     occupancy_next;

  // A response only counts against an entry that is actually ISSUED.
  assign resp_hit = l2_response_valid &&
                    ({1'b0, l2_response_idx} < (IDX_WIDTH+1)'(NUM_ENTRIES)) &&
                    (state[l2_response_idx] == ST_ISSUED);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
      assign is_free[gi]    = (state[gi] == ST_FREE);
      assign is_pending[gi] = (state[gi] == ST_PENDING);
      // An entry being completed this cycle cannot absorb a new waiter.
      assign is_match[gi]   = !is_free[gi] && !entry_sync[gi] &&
                              (line_adr[gi] == cache_miss_adr) &&
                              !(resp_hit && (l2_response_idx == IDX_WIDTH'(gi)));
      assign is_oldest[gi]  = is_pending[gi] && !(|(elder[gi] & is_pending));
      assign thread_busy[gi] = !is_free[gi] && waiters[gi][cache_miss_thread_idx] &&
                               !(resp_hit && (l2_response_idx == IDX_WIDTH'(gi)));
    end
  endgenerate

  // Priority pick: lowest free slot, lowest combine target, oldest pending.
  always_comb begin
    free_any    = 1'b0;
    alloc_idx   = '0;
    combine_hit = 1'b0;
    combine_idx = '0;
    deq_idx     = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (is_free[i]) begin
        free_any  = 1'b1;
        alloc_idx = IDX_WIDTH'(i);
      end
      if (is_match[i]) begin
        combine_hit = 1'b1;
        combine_idx = IDX_WIDTH'(i);
      end
      if (is_oldest[i]) deq_idx = IDX_WIDTH'(i);
    end
  end

  // Miss handling decision and occupancy bookkeeping for this edge.
  always_comb begin
    thread_bit = '0;
    thread_bit[cache_miss_thread_idx] = 1'b1;
    do_combine = cache_miss && !cache_miss_sync && combine_hit;
    do_alloc   = cache_miss && !do_combine && free_any;
    alloc_mask = '0;
    if (do_alloc) alloc_mask[alloc_idx] = 1'b1;
    deq_fire   = dequeue_ack && (|is_pending);
    occupancy_next = occupancy + (IDX_WIDTH+1)'(do_alloc) - (IDX_WIDTH+1)'(resp_hit);
  end

  assign cache_miss_accept = do_combine || do_alloc;
  assign dequeue_ready     = |is_pending;
  assign dequeue_idx       = deq_idx;
  assign dequeue_adr       = dequeue_ready ? line_adr[deq_idx] : '0;
  assign dequeue_sync      = dequeue_ready && entry_sync[deq_idx];

  // Per-entry state, payload and age-matrix updates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state[i]      <= ST_FREE;
        line_adr[i]   <= '0;
        entry_sync[i] <= 1'b0;
        waiters[i]    <= '0;
        elder[i]      <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        elder[i] <= elder[i] & ~alloc_mask;
        if (do_alloc && (alloc_idx == IDX_WIDTH'(i))) begin
          state[i]      <= ST_PENDING;
          line_adr[i]   <= cache_miss_adr;
          entry_sync[i] <= cache_miss_sync;
          waiters[i]    <= thread_bit;
          elder[i]      <= ~is_free & ~alloc_mask;
        end else if (resp_hit && (l2_response_idx == IDX_WIDTH'(i))) begin
          state[i] <= ST_FREE;
        end else if (deq_fire && (deq_idx == IDX_WIDTH'(i))) begin
          state[i] <= ST_ISSUED;
        end
        if (do_combine && (combine_idx == IDX_WIDTH'(i))) begin
          waiters[i] <= waiters[i] | thread_bit;
        end
      end
    end
  end

  // Wake pulse and occupancy counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wake_bitmap <= '0;
      occupancy   <= '0;
    end else begin
      wake_bitmap <= resp_hit ? waiters[l2_response_idx] : '0;
      occupancy   <= occupancy_next;
    end
  end

`ifdef L1_MISS_TRACKER_PERF_EN
  // Performance pulses and occupancy high-water mark.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_miss_combined  <= 1'b0;
      perf_miss_stall     <= 1'b0;
      perf_peak_occupancy <= '0;
    end else begin
      perf_miss_combined <= do_combine;
      perf_miss_stall    <= cache_miss && !cache_miss_accept;
      if (occupancy_next > perf_peak_occupancy) perf_peak_occupancy <= occupancy_next;
    end
  end
`endif

`ifndef SYNTHESIS
  // A thread may only have one outstanding miss at a time.
  always @(posedge clk) begin
    if (reset && cache_miss_accept) assert (thread_busy == '0);
  end
`endif

endmodule

// File: tb/tb_l1_miss_tracker.sv
// Testbench for l1_miss_tracker: directed scenarios with literal checks,
// then randomized traffic, all compared every cycle against a queue-based
// reference model of the tracker.
module tb_l1_miss_tracker;
  localparam int NT = 8;
  localparam int NE = 4;
  localparam int AW = 26;
  localparam int IW = 2;
  localparam int TW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cache_miss = 1'b0;
  logic [AW-1:0] cache_miss_adr = '0;
  logic [TW-1:0] cache_miss_thread_idx = '0;
  logic          cache_miss_sync = 1'b0;
  logic          cache_miss_accept;
  logic          dequeue_ready;
  logic          dequeue_ack = 1'b0;
  logic [AW-1:0] dequeue_adr;
  logic [IW-1:0] dequeue_idx;
  logic          dequeue_sync;
  logic          l2_response_valid = 1'b0;
  logic [IW-1:0] l2_response_idx = '0;
  logic [NT-1:0] wake_bitmap;
  logic [IW:0]   occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  l1_miss_tracker #(.NUM_THREADS(NT), .NUM_ENTRIES(NE), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .cache_miss(cache_miss), .cache_miss_adr(cache_miss_adr),
    .cache_miss_thread_idx(cache_miss_thread_idx), .cache_miss_sync(cache_miss_sync),
    .cache_miss_accept(cache_miss_accept),
    .dequeue_ready(dequeue_ready), .dequeue_ack(dequeue_ack),
    .dequeue_adr(dequeue_adr), .dequeue_idx(dequeue_idx), .dequeue_sync(dequeue_sync),
    .l2_response_valid(l2_response_valid), .l2_response_idx(l2_response_idx),
    .wake_bitmap(wake_bitmap), .occupancy(occupancy)
  );

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // m_state: 0 free, 1 waiting for L2 issue, 2 issued. m_order lists live
  // entries in allocation order, so the oldest waiting entry is the first
  // one in that list still waiting.
  int            m_state [NE];
  logic [AW-1:0] m_adr   [NE];
  bit            m_sync  [NE];
  logic [NT-1:0] m_bmp   [NE];
  int            m_order [$];
  logic [NT-1:0] m_wake;

  function automatic void model_reset();
    for (int e = 0; e < NE; e++) begin
      m_state[e] = 0; m_adr[e] = '0; m_sync[e] = 0; m_bmp[e] = '0;
    end
    m_order.delete();
    m_wake = '0;
  endfunction

  function automatic int m_oldest_pending();
    foreach (m_order[k]) if (m_state[m_order[k]] == 1) return m_order[k];
    return -1;
  endfunction

  function automatic int m_first_free();
    for (int e = 0; e < NE; e++) if (m_state[e] == 0) return e;
    return -1;
  endfunction

  function automatic bit m_resp_effective();
    return l2_response_valid && (m_state[int'(l2_response_idx)] == 2);
  endfunction

  function automatic int m_combine_target();
    if (!cache_miss || cache_miss_sync) return -1;
    for (int e = 0; e < NE; e++) begin
      if (m_state[e] != 0 && !m_sync[e] && m_adr[e] == cache_miss_adr &&
          !(m_resp_effective() && e == int'(l2_response_idx))) return e;
    end
    return -1;
  endfunction

  function automatic bit m_accept();
    return cache_miss && (m_combine_target() >= 0 || m_first_free() >= 0);
  endfunction

  function automatic int m_occ();
    int n = 0;
    for (int e = 0; e < NE; e++) if (m_state[e] != 0) n++;
    return n;
  endfunction

  function automatic bit thread_in_model(int t);
    for (int e = 0; e < NE; e++) if (m_state[e] != 0 && m_bmp[e][t]) return 1;
    return 0;
  endfunction

  function automatic void model_step();
    int tgt = m_combine_target();
    int fr  = m_first_free();
    int op  = m_oldest_pending();
    bit re  = m_resp_effective();
    int ri  = int'(l2_response_idx);
    logic [NT-1:0] tb_bit = '0;
    tb_bit[cache_miss_thread_idx] = 1'b1;
    m_wake = '0;
    if (re) begin
      m_wake = m_bmp[ri];
      m_state[ri] = 0;
      for (int k = 0; k < m_order.size(); k++) begin
        if (m_order[k] == ri) begin m_order.delete(k); break; end
      end
    end
    if (dequeue_ack && op >= 0) m_state[op] = 2;
    if (cache_miss) begin
      if (tgt >= 0) m_bmp[tgt] |= tb_bit;
      else if (fr >= 0) begin
        m_state[fr] = 1; m_adr[fr] = cache_miss_adr; m_sync[fr] = cache_miss_sync;
        m_bmp[fr] = tb_bit; m_order.push_back(fr);
      end
    end
  endfunction

  // Every-cycle comparison against the model, then advance the model over
  // the coming rising edge using the inputs now being presented.
  int cmp_op;
  always @(negedge clk) begin
    if (!reset) begin
      model_reset();
      check("rst_occupancy", occupancy, 0);
      check("rst_deq_ready", dequeue_ready, 0);
      check("rst_wake", wake_bitmap, 0);
    end else begin
      cmp_op = m_oldest_pending();
      check("accept", cache_miss_accept, m_accept());
      check("deq_ready", dequeue_ready, cmp_op >= 0);
      check("deq_adr", dequeue_adr, (cmp_op >= 0) ? m_adr[cmp_op] : '0);
      check("deq_idx", dequeue_idx, (cmp_op >= 0) ? cmp_op : 0);
      check("deq_sync", dequeue_sync, (cmp_op >= 0) ? m_sync[cmp_op] : 0);
      check("occupancy", occupancy, m_occ());
      check("wake", wake_bitmap, m_wake);
      model_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_miss(input logic [AW-1:0] adr, input int thr, input bit snc);
    bit done = 0;
    cache_miss = 1'b1; cache_miss_adr = adr;
    cache_miss_thread_idx = TW'(thr); cache_miss_sync = snc;
    for (int k = 0; k < 50 && !done; k++) begin
      #1;
      done = cache_miss_accept;
      tick();
    end
    if (!done) check("miss_accept_timeout", 0, 1);
    cache_miss = 1'b0;
  endtask

  task automatic ack();
    dequeue_ack = 1'b1; tick(); dequeue_ack = 1'b0;
  endtask

  task automatic respond(input int idx);
    l2_response_valid = 1'b1; l2_response_idx = IW'(idx); tick(); l2_response_valid = 1'b0;
  endtask

  task automatic drain();
    cache_miss = 1'b0;
    repeat (NE) ack();
    for (int i = 0; i < NE; i++) respond(i);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // Combine and order.
    send_miss(26'h123, 0, 0);
    send_miss(26'h1b2, 1, 0);
    check("t1_occ_two", occupancy, 2);
    send_miss(26'h1b2, 2, 0);
    check("t1_occ_after_combine", occupancy, 2);
    check("t1_first_adr", dequeue_adr, 26'h123);
    ack();
    check("t1_second_adr", dequeue_adr, 26'h1b2);
    ack();
    respond(0);
    check("t1_wake_first", wake_bitmap, 8'h01);
    respond(1);
    check("t1_wake_second", wake_bitmap, 8'h06);
    check("t1_occ_zero", occupancy, 0);

    // Sync isolation.
    send_miss(26'ha12, 0, 1);
    send_miss(26'ha12, 1, 0);
    check("t2_occ", occupancy, 2);
    check("t2_first_sync", dequeue_sync, 1);
    ack();
    check("t2_second_sync", dequeue_sync, 0);
    check("t2_second_idx", dequeue_idx, 1);
    ack();
    respond(0);
    check("t2_wake_sync", wake_bitmap, 8'h01);
    respond(1);
    check("t2_wake_plain", wake_bitmap, 8'h02);

    // Full tracker and retry after a response.
    send_miss(26'h10, 0, 0);
    send_miss(26'h20, 1, 0);
    send_miss(26'h30, 2, 0);
    send_miss(26'h40, 3, 0);
    check("t3_occ_full", occupancy, 4);
    cache_miss = 1'b1; cache_miss_adr = 26'h50; cache_miss_thread_idx = 3'd4; cache_miss_sync = 0;
    #1 check("t3_stall", cache_miss_accept, 0);
    tick();
    ack();
    l2_response_valid = 1'b1; l2_response_idx = 2'd0;
    #1 check("t3_no_reuse_same_cycle", cache_miss_accept, 0);
    tick();
    l2_response_valid = 1'b0;
    check("t3_wake", wake_bitmap, 8'h01);
    check("t3_retry_accept", cache_miss_accept, 1);
    tick();
    cache_miss = 1'b0;
    check("t3_oldest_after_reuse", dequeue_adr, 26'h20);
    drain();

    // Response / combine race.
    send_miss(26'h1b2, 1, 0);
    send_miss(26'h1b2, 2, 0);
    ack();
    l2_response_valid = 1'b1; l2_response_idx = 2'd0;
    cache_miss = 1'b1; cache_miss_adr = 26'h1b2; cache_miss_thread_idx = 3'd3; cache_miss_sync = 0;
    #1 check("t4_race_accept", cache_miss_accept, 1);
    tick();
    l2_response_valid = 1'b0; cache_miss = 1'b0;
    check("t4_old_wake", wake_bitmap, 8'h06);
    check("t4_occ", occupancy, 1);
    check("t4_new_idx", dequeue_idx, 1);
    ack();
    respond(1);
    check("t4_new_wake", wake_bitmap, 8'h08);

    // Stability under held ack and spurious responses.
    send_miss(26'h77, 0, 0);
    for (int c = 0; c < 5; c++) begin
      cache_miss = (c == 1) || (c == 3);
      cache_miss_adr = (c == 1) ? 26'h88 : 26'h99;
      cache_miss_thread_idx = (c == 1) ? 3'd1 : 3'd2;
      cache_miss_sync = 0;
      tick();
      check("t5_stable_adr", dequeue_adr, 26'h77);
      check("t5_stable_idx", dequeue_idx, 0);
    end
    cache_miss = 1'b0;
    check("t5_occ", occupancy, 3);
    respond(3);
    check("t5_free_resp_wake", wake_bitmap, 0);
    respond(1);
    check("t5_pending_resp_wake", wake_bitmap, 0);
    check("t5_occ_unchanged", occupancy, 3);
    drain();

    // Asynchronous reset mid-operation.
    send_miss(26'h11, 0, 0);
    send_miss(26'h22, 1, 0);
    send_miss(26'h33, 2, 0);
    ack();
    ack();
    respond(0);
    check("t6_wake_before_reset", wake_bitmap, 8'h01);
    reset = 1'b0;
    #1;
    check("t6_rst_occ", occupancy, 0);
    check("t6_rst_wake", wake_bitmap, 0);
    check("t6_rst_ready", dequeue_ready, 0);
    check("t6_rst_adr", dequeue_adr, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    send_miss(26'h44, 4, 0);
    check("t6_first_idx", dequeue_idx, 0);
    check("t6_first_adr", dequeue_adr, 26'h44);
    drain();

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!(cache_miss && !thread_in_model(int'(cache_miss_thread_idx)))) begin
        int t;
        cache_miss = 1'b0;
        t = $urandom_range(0, NT - 1);
        if ($urandom_range(0, 99) < 60 && !thread_in_model(t)) begin
          cache_miss = 1'b1;
          cache_miss_thread_idx = TW'(t);
          cache_miss_adr = AW'($urandom_range(0, 5));
          cache_miss_sync = ($urandom_range(0, 4) == 0);
        end
      end
      dequeue_ack = $urandom_range(0, 1);
      l2_response_valid = ($urandom_range(0, 99) < 40);
      l2_response_idx = IW'($urandom_range(0, NE - 1));
      tick();
    end
    dequeue_ack = 1'b0; l2_response_valid = 1'b0;
    drain();
    check("final_occ", occupancy, 0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
